// File: rtl/guess_pkg.sv
// Shared types and widths for the guessing-game round controller and its matcher.
package guess_pkg;

    localparam int GUESS_W = 6;
    localparam int CNT_W   = 3;
    localparam int TRIES_W = 4;

    localparam logic [CNT_W-1:0] WIN_COUNT = 3'd6;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        EVAL = 3'd2,
        WIN  = 3'd3,
        LOSE = 3'd4
    } state_t;

    function automatic logic [CNT_W-1:0] cnt_max(input logic [CNT_W-1:0] x,
                                                 input logic [CNT_W-1:0] y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/guess_round_match.sv
// Combinational match counter: number of guess bits a..f equal to the matching answer bit.
module guess_round_match
    import guess_pkg::*;
(
    input  logic [GUESS_W-1:0] ans,
    input  logic               a,
    input  logic               b,
    input  logic               c,
    input  logic               d,
    input  logic               e,
    input  logic               f,
    output logic [CNT_W-1:0]   count
);

    logic [GUESS_W-1:0] eq;

    always_comb begin
        eq    = ~(ans ^ {f, e, d, c, b, a});
        count = '0;
        for (int i = 0; i < GUESS_W; i++)
            count = count + CNT_W'(eq[i]);
    end

endmodule

// File: rtl/guess_round.sv
// Round controller around the internal matcher: latches answer/guesses, tracks tries and best score.
// Optional GUESS_HINT_EN adds a registered per-bit match mask on hint_mask.
module guess_round
    import guess_pkg::*;
#(
    parameter int MAX_TRIES = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [GUESS_W-1:0] ans_in,
    input  logic               guess_valid,
    input  logic [GUESS_W-1:0] guess_in,
    output logic               guess_ready,
    output logic [GUESS_W-1:0] ans_q,
    output logic [GUESS_W-1:0] guess_q,
    output logic [CNT_W-1:0]   last_count,
    output logic [CNT_W-1:0]   best_count,
    output logic [TRIES_W-1:0] tries,
    output logic               busy,
    output logic               win,
    output logic               lose
`ifdef GUESS_HINT_EN
    ,
    output logic [GUESS_W-1:0] hint_mask
`endif
);

    localparam logic [TRIES_W-1:0] TRIES_LAST = TRIES_W'(MAX_TRIES);

    state_t           state;
    logic [CNT_W-1:0] count;

    guess_round_match u_match (
        .ans   (ans_q),
        .a     (guess_q[0]),
        .b     (guess_q[1]),
        .c     (guess_q[2]),
        .d     (guess_q[3]),
        .e     (guess_q[4]),
        .f     (guess_q[5]),
        .count (count)
    );

    // Status flags are registered alongside the state so they are clean decodes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ans_q       <= '0;
            guess_q     <= '0;
            last_count  <= '0;
            best_count  <= '0;
            tries       <= '0;
            guess_ready <= 1'b0;
            busy        <= 1'b0;
            win         <= 1'b0;
            lose        <= 1'b0;
`ifdef GUESS_HINT_EN
            hint_mask   <= '0;
`endif
        end else begin
            case (state)
                IDLE, WIN, LOSE: begin
                    if (start) begin
                        state       <= WAIT;
                        ans_q       <= ans_in;
                        guess_q     <= '0;
                        last_count  <= '0;
                        best_count  <= '0;
                        tries       <= '0;
                        guess_ready <= 1'b1;
                        busy        <= 1'b1;
                        win         <= 1'b0;
                        lose        <= 1'b0;
`ifdef GUESS_HINT_EN
                        hint_mask   <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (guess_valid) begin
                        state       <= EVAL;
                        guess_q     <= guess_in;
                        guess_ready <= 1'b0;
                    end
                end
                EVAL: begin
                    last_count <= count;
                    best_count <= cnt_max(best_count, count);
                    tries      <= tries + 1'b1;
`ifdef GUESS_HINT_EN
                    hint_mask  <= ~(ans_q ^ guess_q);
`endif
                    // A win on the final try still counts as a win.
                    if (count == WIN_COUNT) begin
                        state <= WIN;
                        busy  <= 1'b0;
                        win   <= 1'b1;
                    end else if (tries + 1'b1 == TRIES_LAST) begin
                        state <= LOSE;
                        busy  <= 1'b0;
                        lose  <= 1'b1;
                    end else begin
                        state       <= WAIT;
                        guess_ready <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    guess_ready <= 1'b0;
                    busy        <= 1'b0;
                    win         <= 1'b0;
                    lose        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_guess_round.sv
// Scoreboard bench for guess_round (MAX_TRIES=3): stimulus pushes per-guess expectations, a monitor checks each evaluation.
module tb_guess_round;

    logic       clk = 1'b0;
    logic       reset, start, guess_valid;
    logic [5:0] ans_in, guess_in;
    logic       guess_ready, busy, win, lose;
    logic [5:0] ans_q, guess_q;
    logic [2:0] last_count, best_count;
    logic [3:0] tries;
`ifdef GUESS_HINT_EN
    logic [5:0] hint_mask;
`endif

    typedef struct {
        logic [2:0] lc;
        logic [2:0] bc;
        logic [3:0] tr;
        logic       w;
        logic       l;
        logic [5:0] hm;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    guess_round #(.MAX_TRIES(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ans_in      (ans_in),
        .guess_valid (guess_valid),
        .guess_in    (guess_in),
        .guess_ready (guess_ready),
        .ans_q       (ans_q),
        .guess_q     (guess_q),
        .last_count  (last_count),
        .best_count  (best_count),
        .tries       (tries),
        .busy        (busy),
        .win         (win),
        .lose        (lose)
`ifdef GUESS_HINT_EN
        ,
        .hint_mask   (hint_mask)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " ans_q"}, {2'b0, ans_q}, 8'h00);
        chk({tag, " guess_q"}, {2'b0, guess_q}, 8'h00);
        chk({tag, " last_count"}, {5'b0, last_count}, 8'h00);
        chk({tag, " best_count"}, {5'b0, best_count}, 8'h00);
        chk({tag, " tries"}, {4'b0, tries}, 8'h00);
        chk({tag, " flags"}, {4'b0, guess_ready, busy, win, lose}, 8'h00);
`ifdef GUESS_HINT_EN
        chk({tag, " hint_mask"}, {2'b0, hint_mask}, 8'h00);
`endif
    endtask

    task automatic start_round(input logic [5:0] ans);
        start  = 1'b1;
        ans_in = ans;
        tick();
        start  = 1'b0;
        chk("start ans_q", {2'b0, ans_q}, {2'b0, ans});
        chk("start ready/busy", {6'b0, guess_ready, busy}, 8'h03);
        chk("start tries", {4'b0, tries}, 8'h00);
`ifdef GUESS_HINT_EN
        chk("start hint cleared", {2'b0, hint_mask}, 8'h00);
`endif
    endtask

    task automatic push_exp(input logic [2:0] lc, input logic [2:0] bc, input logic [3:0] tr,
                            input logic w, input logic l, input logic [5:0] hm);
        exp_t e;
        e.lc = lc; e.bc = bc; e.tr = tr; e.w = w; e.l = l; e.hm = hm;
        sb.push_back(e);
    endtask

    task automatic do_guess(input logic [5:0] g, input logic [2:0] lc, input logic [2:0] bc,
                            input logic [3:0] tr, input logic w, input logic l, input logic [5:0] hm);
        chk("ready before guess", {7'b0, guess_ready}, 8'h01);
        guess_valid = 1'b1;
        guess_in    = g;
        push_exp(lc, bc, tr, w, l, hm);
        tick();
        guess_valid = 1'b0;
        chk("eval ready/busy", {6'b0, guess_ready, busy}, 8'h01);
        chk("eval guess_q", {2'b0, guess_q}, {2'b0, g});
        tick();
    endtask

    // Monitor: each evaluation bumps tries to a nonzero value; that is the response event.
    initial begin
        logic [3:0] prev;
        exp_t e;
        prev = '0;
        forever begin
            @(negedge clk);
            if (tries !== prev && tries !== 4'd0) begin
                if (sb.size() == 0) begin
                    chk("unexpected eval", 8'h01, 8'h00);
                end else begin
                    e = sb.pop_front();
                    chk("last_count", {5'b0, last_count}, {5'b0, e.lc});
                    chk("best_count", {5'b0, best_count}, {5'b0, e.bc});
                    chk("tries", {4'b0, tries}, {4'b0, e.tr});
                    chk("win/lose", {6'b0, win, lose}, {6'b0, e.w, e.l});
`ifdef GUESS_HINT_EN
                    chk("hint_mask", {2'b0, hint_mask}, {2'b0, e.hm});
`endif
                end
            end
            prev = tries;
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; guess_valid = 1'b0;
        ans_in = '0; guess_in = '0;
        tick(); tick();
        chk_idle("reset");
        reset = 1'b0;
        tick();

        // Exact first guess wins.
        start_round(6'b101010);
        do_guess(6'b101010, 3'd6, 3'd6, 4'd1, 1'b1, 1'b0, 6'b111111);
        chk("win busy low", {6'b0, busy, guess_ready}, 8'h00);

        // Three misses exhaust MAX_TRIES.
        start_round(6'b000000);
        do_guess(6'b000011, 3'd4, 3'd4, 4'd1, 1'b0, 1'b0, 6'b111100);
        do_guess(6'b000001, 3'd5, 3'd5, 4'd2, 1'b0, 1'b0, 6'b111110);
        do_guess(6'b111111, 3'd0, 3'd5, 4'd3, 1'b0, 1'b1, 6'b000000);
        tick();
        chk("lose hold", {2'b0, lose, win, tries}, {2'b0, 1'b1, 1'b0, 4'd3});

        // Exact guess on the last try wins.
        start_round(6'b110000);
        do_guess(6'b100001, 3'd4, 3'd4, 4'd1, 1'b0, 1'b0, 6'b101110);
        do_guess(6'b000000, 3'd4, 3'd4, 4'd2, 1'b0, 1'b0, 6'b001111);
        do_guess(6'b110000, 3'd6, 3'd6, 4'd3, 1'b1, 1'b0, 6'b111111);

        // Continuous guess_valid: one acceptance every other cycle.
        start_round(6'b010101);
        guess_valid = 1'b1;
        guess_in    = 6'b000000;
        for (int i = 0; i < 3; i++) begin
            chk("stream ready high", {7'b0, guess_ready}, 8'h01);
            push_exp(3'd3, 3'd3, 4'(i + 1), 1'b0, (i == 2), 6'b101010);
            tick();
            chk("stream ready low", {7'b0, guess_ready}, 8'h00);
            tick();
        end
        tick();
        guess_valid = 1'b0;
        chk("stream lose hold", {3'b0, lose, tries}, {3'b0, 1'b1, 4'd3});

        // start inside WAIT is ignored.
        start_round(6'b111000);
        start  = 1'b1;
        ans_in = 6'b000111;
        tick();
        start  = 1'b0;
        chk("start in WAIT ans_q", {2'b0, ans_q}, {2'b0, 6'b111000});
        chk("start in WAIT ready", {7'b0, guess_ready}, 8'h01);
        do_guess(6'b111000, 3'd6, 3'd6, 4'd1, 1'b1, 1'b0, 6'b111111);

        // Reset during EVAL aborts the round.
        start_round(6'b000111);
        guess_valid = 1'b1;
        guess_in    = 6'b000000;
        tick();
        guess_valid = 1'b0;
        chk("pre-abort busy", {7'b0, busy}, 8'h01);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_idle("abort");
        start_round(6'b001100);
        do_guess(6'b001100, 3'd6, 3'd6, 4'd1, 1'b1, 1'b0, 6'b111111);

        repeat (3) tick();
        chk("scoreboard drained", 8'(sb.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/guess_round.md
# guess_round

Sequential round controller downstream of the combinational 6-bit match counter. It latches a secret answer and successive guesses, presents them to the matcher, and consumes the matcher's 3-bit match count. It also tracks attempts and best score, and declares win or lose. It is the stateful game layer wrapped around the matcher.

## Interface
- MAX_TRIES, 8, guesses allowed per round; legal range 1..15
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a round; honoured only in IDLE, WIN or LOSE
- ans_in  in  6  secret answer, sampled on an honoured start
- guess_valid  in  1  guess offered
- guess_in  in  6  guess bits; bit0..bit5 map to matcher a..f
- guess_ready  out  1  block accepts a guess this cycle
- ans_q  out  6  registered answer, driven to the matcher's ans
- guess_q  out  6  registered guess, driven to the matcher's a..f
- count  in  3  matcher result for ans_q/guess_q (combinational return)
- last_count  out  3  count of the most recent evaluated guess
- best_count  out  3  maximum count seen this round
- tries  out  4  guesses evaluated this round
- busy  out  1  high in WAIT or EVAL
- win  out  1  high in WIN
- lose  out  1  high in LOSE
- hint_mask  out  6  only with GUESS_HINT_EN: bit i=1 where guess bit i matched

## Operation
- FSM states: IDLE, WAIT, EVAL, WIN, LOSE.
- IDLE/WIN/LOSE with start=1:
  - latch ans_in into ans_q
  - clear tries, last_count, best_count, guess_q (and hint_mask)
  - go to WAIT
- WAIT: guess_ready=1. When guess_valid=1, latch guess_in into guess_q and go to EVAL. Without guess_valid, stay in WAIT.
- EVAL: guess_ready=0. Sample count, then:
  - last_count<=count
  - best_count<=max(best_count,count)
  - tries<=tries+1
- EVAL next state:
  - count==6 → WIN (a win takes priority even on the final try)
  - otherwise, tries+1==MAX_TRIES → LOSE
  - otherwise → WAIT
- count==7 is illegal from the matcher. It is recorded as-is, is not a win, and counts as a try.
- WIN/LOSE: all outputs hold until start or reset.
- start in WAIT or EVAL is ignored; the round is not restartable mid-play.
- guess_valid outside WAIT is ignored and not queued.
- tries never exceeds MAX_TRIES and never wraps.

## Timing
- Reset values (reset has priority over all other inputs):
  - state IDLE
  - every output register 0: ans_q, guess_q, last_count, best_count, tries, hint_mask
  - guess_ready, busy, win, lose all 0
- Reset mid-round aborts immediately and returns to IDLE on the next edge.
- start → WAIT (guess_ready=1) one cycle later.
- Guess accept → EVAL next cycle.
- EVAL → updated stats and the new state one cycle later.
- Per-guess throughput is 2 cycles: guess_ready is high on alternate cycles under continuous guess_valid.
- count must be valid in EVAL, meaning within one cycle of guess_q changing. The matcher is purely combinational, so this holds.
- win/lose are registered state decodes, asserted the cycle after EVAL.

## Configuration
- GUESS_HINT_EN defined:
  - hint_mask is registered in EVAL as ~(ans_q ^ guess_q)
  - hint_mask is cleared on reset and on an honoured start
- GUESS_HINT_EN undefined: the hint_mask port and its register are absent.
- No other behaviour changes with the macro.

## Structure
- Shared package guess_pkg holds:
  - the state enum (IDLE, WAIT, EVAL, WIN, LOSE)
  - GUESS_W=6, CNT_W=3, TRIES_W=4
  - WIN_COUNT=3'd6
- Sub-module: instantiate the existing matcher internally as u_match, wired ans_q→ans and guess_q[0..5]→a..f. The count port then becomes an internal net. A build-time choice between internal and external matcher is not provided; the matcher is always internal.

## Test plan
- reset, start with ans_in=6'b101010, guess 6'b101010 → EVAL next cycle, then win=1, tries=1, last_count=6, best_count=6.
- MAX_TRIES=3, ans 6'b000000, guesses 6'b000011, 6'b000001, 6'b111111 → last_counts 4,5,0; best_count=5; lose=1 after the third EVAL; tries=3.
- Last guess exact (MAX_TRIES=2, second guess matches) → win=1, lose=0.
- guess_valid held high continuously → guess_ready toggles 1,0,1,0; one guess per 2 cycles. start pulsed in WAIT → ignored, ans_q unchanged.
- reset asserted during EVAL → next cycle all outputs 0, state IDLE; a subsequent start works normally.
- GUESS_HINT_EN: ans 6'b110000, guess 6'b100001 → hint_mask=6'b101110.
